// File: rtl/data_capture_fifo.sv
// data_capture_fifo
//   Buffers {address, data} result pairs from the 2-bit data/select stage
//   in a small first-word-fall-through FIFO. Both sides use a valid/ready
//   handshake. This lets a slow consumer drain results without losing any.
//
// Ports
//   clk, rst             rising-edge clock; synchronous active-high reset
//   in_valid/in_ready    producer handshake (in_ready = !full)
//   in_d, in_a           result data and its address tag
//   out_valid/out_ready  consumer handshake (out_valid = !empty)
//   out_d, out_a         head entry; driven to 0 while empty
//   count                occupancy 0..DEPTH
//   full, empty          occupancy flags
//
// Every status output is decoded from registered state only. As a result,
// no combinational path runs from in_valid or out_ready to an output.
module data_capture_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 2,
  parameter int ADDR_W = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_d,
  input  logic [ADDR_W-1:0]          in_a,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_d,
  output logic [ADDR_W-1:0]          out_a,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   cnt;
  logic               push, pop;

  assign full      = (cnt == CNT_W'(DEPTH));
  assign empty     = (cnt == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign count     = cnt;

  // A push is blocked while full, even if a pop happens in the same cycle.
  // in_ready comes only from the registered count.
  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // The pointers wrap by natural overflow because DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is not reset. Its contents cannot be seen until they are written.
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= '{a: in_a, d: in_d};
  end

  // Fall-through head. It is masked while empty so stale data never leaks out.
  entry_t head;
  always_comb begin
    head = '0;
    if (!empty) head = mem[rd_ptr];
  end

  assign out_d = head.d;
  assign out_a = head.a;

endmodule

// File: tb/tb_data_capture_fifo.sv
module tb_data_capture_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready;
  logic [1:0] in_d, in_a;
  logic       out_valid, out_ready;
  logic [1:0] out_d, out_a;
  logic [2:0] count;
  logic       full, empty;

  int pass_cnt = 0;
  int total_cnt = 0;

  data_capture_fifo #(.DEPTH(4), .DATA_W(2), .ADDR_W(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_d(in_d), .in_a(in_a),
    .out_valid(out_valid), .out_ready(out_ready), .out_d(out_d), .out_a(out_a),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  // Status vector: {count[2:0], full, empty, in_ready, out_valid}.
  function automatic logic [6:0] stat();
    return {count, full, empty, in_ready, out_valid};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_d = '0; in_a = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    total_cnt++;
    if (stat() !== 7'b000_0110) $display("FAIL reset_status got=%b exp=%b", stat(), 7'b000_0110);
    else pass_cnt++;
    total_cnt++;
    if ({out_a, out_d} !== 4'b0000) $display("FAIL reset_out got=%b exp=0000", {out_a, out_d});
    else pass_cnt++;
  endtask

  task automatic test_single_push();
    in_valid = 1'b1; in_a = 2'b01; in_d = 2'b10; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    total_cnt++;
    if (stat() !== 7'b001_0011) $display("FAIL single_status got=%b exp=%b", stat(), 7'b001_0011);
    else pass_cnt++;
    total_cnt++;
    if ({out_a, out_d} !== 4'b0110) $display("FAIL single_head got=%b exp=0110", {out_a, out_d});
    else pass_cnt++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total_cnt++;
    if ({stat(), out_a, out_d} !== 11'b000_0110_0000)
      $display("FAIL single_drain got=%b exp=%b", {stat(), out_a, out_d}, 11'b000_0110_0000);
    else pass_cnt++;
  endtask

  task automatic test_fill_full();
    logic [1:0] ea, ed;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_a = 2'(i); in_d = 2'(3 - i);
      tick();
    end
    total_cnt++;
    if (stat() !== 7'b100_1001) $display("FAIL full_status got=%b exp=%b", stat(), 7'b100_1001);
    else pass_cnt++;
    // Fifth entry held off for three cycles.
    in_a = 2'b00; in_d = 2'b01;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++;
      if (count !== 3'd4) $display("FAIL full_hold[%0d] got=%0d exp=4", i, count);
      else pass_cnt++;
    end
    // Edge0: pop only (push blocked while full). Edge1: the 5th entry is
    // pushed and popped together. The rest drain.
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ea = (i < 4) ? 2'(i) : 2'b00;
      ed = (i < 4) ? 2'(3 - i) : 2'b01;
      total_cnt++;
      if ({out_valid, out_a, out_d} !== {1'b1, ea, ed})
        $display("FAIL full_order[%0d] got=%b exp=%b", i, {out_valid, out_a, out_d}, {1'b1, ea, ed});
      else pass_cnt++;
      tick();
      if (i == 0) begin
        total_cnt++;
        if ({count, in_ready} !== {3'd3, 1'b1})
          $display("FAIL full_release got=%b exp=%b", {count, in_ready}, {3'd3, 1'b1});
        else pass_cnt++;
      end
      if (i == 1) in_valid = 1'b0;
    end
    out_ready = 1'b0;
    total_cnt++;
    if ({stat(), out_a, out_d} !== 11'b000_0110_0000)
      $display("FAIL full_drain got=%b exp=%b", {stat(), out_a, out_d}, 11'b000_0110_0000);
    else pass_cnt++;
  endtask

  task automatic test_stream();
    logic [3:0] k;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      k = 4'(i);
      in_a = k[1:0]; in_d = ~k[1:0];
      tick();
      total_cnt++;
      if ({count, out_a, out_d} !== {3'd1, k[1:0], ~k[1:0]})
        $display("FAIL stream[%0d] got=%b exp=%b", i, {count, out_a, out_d}, {3'd1, k[1:0], ~k[1:0]});
      else pass_cnt++;
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    total_cnt++;
    if (stat() !== 7'b000_0110) $display("FAIL stream_drain got=%b exp=%b", stat(), 7'b000_0110);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_a = 2'(i + 1); in_d = 2'(i);
      tick();
    end
    total_cnt++;
    if (count !== 3'd3) $display("FAIL rstmid_fill got=%0d exp=3", count);
    else pass_cnt++;
    rst = 1'b1; in_a = 2'b11; in_d = 2'b11;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    total_cnt++;
    if ({stat(), out_a, out_d} !== 11'b000_0110_0000)
      $display("FAIL rstmid_clear got=%b exp=%b", {stat(), out_a, out_d}, 11'b000_0110_0000);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (stat() !== 7'b000_0110) $display("FAIL rstmid_nostore got=%b exp=%b", stat(), 7'b000_0110);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [3:0] q[$];
    logic [3:0] pl;
    int errs = 0;
    bit push, pop;
    for (int i = 0; i < 1000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      pl = 4'($urandom);
      in_a = pl[3:2]; in_d = pl[1:0];
      #1;
      total_cnt++;
      if ({count, in_ready, out_valid} !== {3'(q.size()), q.size() < 4, q.size() > 0}) begin
        if (errs < 10) $display("FAIL rand_status[%0d] got=%b exp_size=%0d", i,
                                {count, in_ready, out_valid}, q.size());
        errs++;
      end else pass_cnt++;
      if (q.size() > 0) begin
        total_cnt++;
        if ({out_a, out_d} !== q[0]) begin
          if (errs < 10) $display("FAIL rand_head[%0d] got=%b exp=%b", i, {out_a, out_d}, q[0]);
          errs++;
        end else pass_cnt++;
      end
      push = in_valid && (q.size() < 4);
      pop  = out_ready && (q.size() > 0);
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(pl);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_fill_full();
    test_stream();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
